// File: rtl/real_avg_to_int.sv
// ---------------------------------------------------------------------------
// real_avg_to_int
//
// Decimating averager on the output side of the svreal real-to-integer path.
// Fixed-point samples (signed mantissa, value = mantissa * 2^IN_EXP) arrive
// over a valid/ready handshake. Each window of 2^LOG2_N accepted samples is
// summed. The sum is converted to floor(average value), clamped to a signed
// OUT_WIDTH-bit integer, and offered over an output valid/ready handshake.
//
// Ports:
//   clk        in   1          clock, all state changes on the rising edge
//   rst        in   1          synchronous reset, active-high
//   in_mant    in   IN_WIDTH   signed input mantissa
//   in_valid   in   1          in_mant is valid
//   in_ready   out  1          a sample is accepted this cycle if in_valid
//   out_int    out  OUT_WIDTH  signed averaged integer result
//   out_sat    out  1          out_int was clamped to the output range
//   out_valid  out  1          out_int / out_sat hold a pending result
//   out_ready  in   1          consumer takes the result this cycle
// ---------------------------------------------------------------------------
module real_avg_to_int #(
    parameter int IN_WIDTH  = 16,
    parameter int IN_EXP    = -8,
    parameter int OUT_WIDTH = 8,
    parameter int LOG2_N    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  in_mant,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] out_int,
    output logic                        out_sat,
    output logic                        out_valid,
    input  logic                        out_ready
);

    // Samples per window and derived widths.
    // The accumulator gains LOG2_N bits over the mantissa, which is exactly
    // enough for N full-scale samples of either sign.
    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = IN_WIDTH + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;

    // Dividing by N and scaling by 2^IN_EXP collapse into one right shift.
    // IN_EXP is never positive, so the shift is never negative.
    localparam int SHIFT = LOG2_N - IN_EXP;

    // Working width for the shifted sum. It is one bit wider than both the
    // sum and the output, so the clamp comparisons see the true value.
    localparam int WIDE = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;

    localparam logic signed [WIDE-1:0] OUT_MAX =
        $signed({{(WIDE-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [WIDE-1:0] OUT_MIN =
        $signed({{(WIDE-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

    localparam logic signed [CNT_W-1:0] CNT_FULL = CNT_W'(N);

    // Reject parameter combinations the arithmetic above cannot handle.
    generate
        if (IN_EXP > 0 || IN_EXP < -(IN_WIDTH + LOG2_N)) begin : g_bad_exp
            $error("real_avg_to_int: IN_EXP out of range");
        end
        if (OUT_WIDTH < 2 || OUT_WIDTH > 32) begin : g_bad_out_width
            $error("real_avg_to_int: OUT_WIDTH out of range");
        end
        if (LOG2_N < 0 || LOG2_N > 8) begin : g_bad_log2_n
            $error("real_avg_to_int: LOG2_N out of range");
        end
    endgenerate

    // ACCUM collects samples. HOLD presents a finished result.
    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    logic [0:0]               state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;

    logic signed [ACC_W-1:0]  mant_ext;
    logic signed [ACC_W-1:0]  full_sum;
    logic [CNT_W-1:0]         cnt_next;
    logic signed [WIDE-1:0]   sum_wide;
    logic signed [WIDE-1:0]   q;
    logic signed [OUT_WIDTH-1:0] sat_int;
    logic                     sat_flag;
    logic                     accept;

    // Reset gates in_ready directly. No sample can slip in during the reset
    // cycle, even though the state is only cleared at the edge.
    assign in_ready  = (state == S_ACCUM) && !rst;
    assign out_valid = (state == S_HOLD);
    assign accept    = in_valid && in_ready;

    // Sum that includes the sample being offered this cycle. The final sample
    // of a window is converted straight from this value, which removes a
    // cycle of latency.
    always_comb begin
        mant_ext = ACC_W'(in_mant);
        full_sum = acc + mant_ext;
        cnt_next = cnt + CNT_W'(1);
    end

    // Floor of the average value. An arithmetic shift rounds toward minus
    // infinity, so -1.25 becomes -2. Out-of-range values clamp and raise the
    // saturation flag.
    always_comb begin
        sum_wide = WIDE'(full_sum);
        q        = sum_wide >>> SHIFT;
        sat_int  = q[OUT_WIDTH-1:0];
        sat_flag = 1'b0;
        if (q > OUT_MAX) begin
            sat_int  = OUT_MAX[OUT_WIDTH-1:0];
            sat_flag = 1'b1;
        end else if (q < OUT_MIN) begin
            sat_int  = OUT_MIN[OUT_WIDTH-1:0];
            sat_flag = 1'b1;
        end
    end

    // Main sequencer. Samples accumulate until the window is full. The result
    // registers then load, and the block holds until the consumer takes the
    // result. out_int and out_sat are left alone on release, so the last
    // result stays readable after out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_ACCUM;
            acc     <= '0;
            cnt     <= '0;
            out_int <= '0;
            out_sat <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (accept) begin
                        acc <= full_sum;
                        cnt <= cnt_next;
                        if (cnt_next == CNT_FULL) begin
                            out_int <= sat_int;
                            out_sat <= sat_flag;
                            state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_ACCUM;
                    end
                end
                default: begin
                    state <= S_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_real_avg_to_int.sv
// ---------------------------------------------------------------------------
// tb_real_avg_to_int
//
// Testbench for real_avg_to_int. It drives three instances from the same
// input signals:
//   k=0  default build (OUT_WIDTH=8, LOG2_N=2)
//   k=1  OUT_WIDTH=6, which exercises clamping
//   k=2  LOG2_N=0, which produces a result for every sample
//
// A fixed table checks hand-computed values on instances 0 and 1. A
// behavioural model, built from averaging and floor division, checks every
// instance on every cycle. The table is followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_real_avg_to_int;

    logic               clk;
    logic               rst;
    logic signed [15:0] in_mant;
    logic               in_valid;
    logic               out_ready;

    logic              rdy0, rdy1, rdy2;
    logic              ov0, ov1, ov2;
    logic              sat0, sat1, sat2;
    logic signed [7:0] oi0;
    logic signed [5:0] oi1;
    logic signed [7:0] oi2;

    int total;
    int bad;

    real_avg_to_int #(.IN_WIDTH(16), .IN_EXP(-8), .OUT_WIDTH(8), .LOG2_N(2)) dut0 (
        .clk(clk), .rst(rst), .in_mant(in_mant), .in_valid(in_valid), .in_ready(rdy0),
        .out_int(oi0), .out_sat(sat0), .out_valid(ov0), .out_ready(out_ready));

    real_avg_to_int #(.IN_WIDTH(16), .IN_EXP(-8), .OUT_WIDTH(6), .LOG2_N(2)) dut1 (
        .clk(clk), .rst(rst), .in_mant(in_mant), .in_valid(in_valid), .in_ready(rdy1),
        .out_int(oi1), .out_sat(sat1), .out_valid(ov1), .out_ready(out_ready));

    real_avg_to_int #(.IN_WIDTH(16), .IN_EXP(-8), .OUT_WIDTH(8), .LOG2_N(0)) dut2 (
        .clk(clk), .rst(rst), .in_mant(in_mant), .in_valid(in_valid), .in_ready(rdy2),
        .out_int(oi2), .out_sat(sat2), .out_valid(ov2), .out_ready(out_ready));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: a running sum and sample count per instance, plus a
    // flag for a pending result and the last result delivered.
    int      m_n     [3] = '{4, 4, 1};
    int      m_w     [3] = '{8, 6, 8};
    longint  m_sum   [3];
    int      m_cnt   [3];
    bit      m_pend  [3];
    longint  m_int   [3];
    bit      m_sat   [3];
    bit      exp_rdy [3];
    logic    rdy_seen[3];

    typedef struct {
        logic        r;
        logic        v;
        int          m;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        int          e_int8;
        logic        e_sat8;
        int          e_int6;
        logic        e_sat6;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic r, input logic v, input int m, input logic ordy,
                          input logic e_rdy, input logic e_ov, input int e_int8,
                          input logic e_sat8, input int e_int6, input logic e_sat6);
        vec_t t;
        t.r = r; t.v = v; t.m = m; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov;
        t.e_int8 = e_int8; t.e_sat8 = e_sat8;
        t.e_int6 = e_int6; t.e_sat6 = e_sat6;
        vecs.push_back(t);
    endtask

    task automatic rep(input int count, input logic r, input logic v, input int m,
                       input logic ordy, input logic e_rdy, input logic e_ov,
                       input int e_int8, input logic e_sat8, input int e_int6,
                       input logic e_sat6);
        for (int i = 0; i < count; i++)
            addVec(r, v, m, ordy, e_rdy, e_ov, e_int8, e_sat8, e_int6, e_sat6);
    endtask

    function automatic longint floorDiv(input longint a, input longint b);
        longint qq;
        qq = a / b;
        if ((a % b) != 0 && a < 0)
            qq = qq - 1;
        return qq;
    endfunction

    task automatic checkVal(input string name, input logic signed [63:0] act,
                            input logic signed [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Advance the model by one rising edge, using the inputs that were driven.
    task automatic modelStep();
        longint avg;
        longint mx;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_sum[k] = 0; m_cnt[k] = 0; m_pend[k] = 0; m_int[k] = 0; m_sat[k] = 0;
            end else if (m_pend[k]) begin
                if (out_ready) begin
                    m_pend[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
                end
            end else if (in_valid) begin
                m_sum[k] += longint'(in_mant);
                m_cnt[k]++;
                if (m_cnt[k] == m_n[k]) begin
                    avg = floorDiv(m_sum[k], longint'(m_n[k]) * 256);
                    mx  = (longint'(1) << (m_w[k] - 1)) - 1;
                    if (avg > mx) begin
                        m_int[k] = mx; m_sat[k] = 1;
                    end else if (avg < -mx - 1) begin
                        m_int[k] = -mx - 1; m_sat[k] = 1;
                    end else begin
                        m_int[k] = avg; m_sat[k] = 0;
                    end
                    m_pend[k] = 1;
                end
            end
        end
    endtask

    // Compare every instance against the model after the edge.
    task automatic checkOutput();
        checkVal("ready0", rdy_seen[0], exp_rdy[0]);
        checkVal("ready1", rdy_seen[1], exp_rdy[1]);
        checkVal("ready2", rdy_seen[2], exp_rdy[2]);
        checkVal("valid0", ov0, m_pend[0]);
        checkVal("valid1", ov1, m_pend[1]);
        checkVal("valid2", ov2, m_pend[2]);
        checkVal("int0", oi0, m_int[0]);
        checkVal("int1", oi1, m_int[1]);
        checkVal("int2", oi2, m_int[2]);
        checkVal("sat0", sat0, m_sat[0]);
        checkVal("sat1", sat1, m_sat[1]);
        checkVal("sat2", sat2, m_sat[2]);
    endtask

    // Drive one cycle of inputs, sample in_ready before the edge, step the
    // model, then check the outputs #1 after the edge.
    task automatic applyStimulus(input logic r, input logic v, input int m, input logic ordy);
        @(negedge clk);
        rst = r; in_valid = v; in_mant = 16'(m); out_ready = ordy;
        #1;
        rdy_seen[0] = rdy0; rdy_seen[1] = rdy1; rdy_seen[2] = rdy2;
        for (int k = 0; k < 3; k++)
            exp_rdy[k] = !m_pend[k] && !r;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; in_valid = 1'b0; in_mant = '0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_sum[k] = 0; m_cnt[k] = 0; m_pend[k] = 0; m_int[k] = 0; m_sat[k] = 0;
        end

        // Columns: rst, in_valid, mant, out_ready | in_ready, out_valid,
        // int(w8), sat(w8), int(w6), sat(w6)
        addVec(1, 0, 0, 0,         0, 0, 0, 0, 0, 0);
        // 4 samples of 2.5 give 2
        rep(3, 0, 1, 640, 0,       1, 0, 0, 0, 0, 0);
        addVec(0, 1, 640, 0,       1, 1, 2, 0, 2, 0);
        addVec(0, 0, 0, 0,         0, 1, 2, 0, 2, 0);
        addVec(0, 1, 1000, 1,      0, 0, 2, 0, 2, 0);
        // 4 samples of -1.25 give -2
        rep(3, 0, 1, -320, 0,      1, 0, 2, 0, 2, 0);
        addVec(0, 1, -320, 0,      1, 1, -2, 0, -2, 0);
        addVec(0, 0, 0, 1,         0, 0, -2, 0, -2, 0);
        // {1,2,3,5} averages to 2.75 and gives 2
        addVec(0, 1, 256, 0,       1, 0, -2, 0, -2, 0);
        addVec(0, 1, 512, 0,       1, 0, -2, 0, -2, 0);
        addVec(0, 1, 768, 0,       1, 0, -2, 0, -2, 0);
        addVec(0, 1, 1280, 0,      1, 1, 2, 0, 2, 0);
        addVec(0, 0, 0, 1,         0, 0, 2, 0, 2, 0);
        // 127.0 clamps on the 6-bit output, then 5 cycles of backpressure
        rep(3, 0, 1, 32512, 0,     1, 0, 2, 0, 2, 0);
        addVec(0, 1, 32512, 0,     1, 1, 127, 0, 31, 1);
        rep(5, 0, 1, 1000, 0,      0, 1, 127, 0, 31, 1);
        addVec(0, 1, 1000, 1,      0, 0, 127, 0, 31, 1);
        rep(3, 0, 1, 0, 0,         1, 0, 127, 0, 31, 1);
        addVec(0, 1, 0, 0,         1, 1, 0, 0, 0, 0);
        addVec(0, 0, 0, 1,         0, 0, 0, 0, 0, 0);
        // -128.0 clamps low on the 6-bit output
        rep(3, 0, 1, -32768, 0,    1, 0, 0, 0, 0, 0);
        addVec(0, 1, -32768, 0,    1, 1, -128, 0, -32, 1);
        addVec(0, 0, 0, 1,         0, 0, -128, 0, -32, 1);
        // 31.5 fits in 6 bits and floors to 31
        rep(3, 0, 1, 8064, 0,      1, 0, -128, 0, -32, 1);
        addVec(0, 1, 8064, 0,      1, 1, 31, 0, 31, 0);
        addVec(0, 0, 0, 1,         0, 0, 31, 0, 31, 0);
        // Gapped input: only 1,2,3,4 count
        addVec(0, 1, 256, 0,       1, 0, 31, 0, 31, 0);
        addVec(0, 0, 999, 0,       1, 0, 31, 0, 31, 0);
        addVec(0, 0, 999, 0,       1, 0, 31, 0, 31, 0);
        addVec(0, 1, 512, 0,       1, 0, 31, 0, 31, 0);
        addVec(0, 1, 768, 0,       1, 0, 31, 0, 31, 0);
        addVec(0, 0, 999, 0,       1, 0, 31, 0, 31, 0);
        addVec(0, 1, 1024, 0,      1, 1, 2, 0, 2, 0);
        addVec(0, 0, 0, 1,         0, 0, 2, 0, 2, 0);
        // Reset mid-window discards two samples of 100.0
        rep(2, 0, 1, 25600, 0,     1, 0, 2, 0, 2, 0);
        addVec(1, 1, 25600, 0,     0, 0, 0, 0, 0, 0);
        rep(3, 0, 1, 256, 0,       1, 0, 0, 0, 0, 0);
        addVec(0, 1, 256, 0,       1, 1, 1, 0, 1, 0);
        addVec(0, 0, 0, 1,         0, 0, 1, 0, 1, 0);

        $display("[TB] running %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].v, vecs[i].m, vecs[i].ordy);
            checkVal($sformatf("vec%0d_ready", i), rdy_seen[0], vecs[i].e_rdy);
            checkVal($sformatf("vec%0d_valid", i), ov0, vecs[i].e_ov);
            checkVal($sformatf("vec%0d_int8", i), oi0, vecs[i].e_int8);
            checkVal($sformatf("vec%0d_sat8", i), sat0, vecs[i].e_sat8);
            checkVal($sformatf("vec%0d_int6", i), oi1, vecs[i].e_int6);
            checkVal($sformatf("vec%0d_sat6", i), sat1, vecs[i].e_sat6);
        end

        // Hand sequence: a single-sample window alternates between accepting
        // and holding. 3.75 floors to 3 with a one-cycle result latency.
        applyStimulus(0, 1, 960, 1);
        checkVal("n1_valid", ov2, 1'b1);
        checkVal("n1_int", oi2, 3);
        applyStimulus(0, 1, 960, 1);
        checkVal("n1_release", ov2, 1'b0);
        checkVal("n1_ready_in_hold", rdy_seen[2], 1'b0);
        applyStimulus(0, 0, 0, 1);
        checkVal("n1_ready_back", rdy_seen[2], 1'b1);

        $display("[TB] running randomized phase");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(99) == 0),
                          ($urandom_range(9) < 7),
                          int'($signed(16'($urandom()))),
                          ($urandom_range(1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
